// File: rtl/writeback_stage_pkg.sv
// Shared encodings for the write-back stage: one-hot load widths, one-hot
// write-back sources and the load-buffer FSM states.
package writeback_stage_pkg;

   localparam int unsigned WB_XLEN = 64;

   localparam logic [3:0] MEM_WIDTH_1H_BYTE   = 4'b0001;
   localparam logic [3:0] MEM_WIDTH_1H_HALF   = 4'b0010;
   localparam logic [3:0] MEM_WIDTH_1H_WORD   = 4'b0100;
   localparam logic [3:0] MEM_WIDTH_1H_DOUBLE = 4'b1000;

   localparam logic [2:0] WB_SRC_1H_ALU = 3'b001;
   localparam logic [2:0] WB_SRC_1H_MEM = 3'b010;
   localparam logic [2:0] WB_SRC_1H_CSR = 3'b100;

   typedef enum logic {
      LB_IDLE = 1'b0,
      LB_HELD = 1'b1
   } lb_state_e;

endpackage

// File: rtl/writeback_stage_load_align_ext.sv
// Load data alignment: shifts the addressed bytes down to bit 0 and sign- or
// zero-extends them to 64 bits. Purely combinational.
module writeback_stage_load_align_ext
   import writeback_stage_pkg::*;
(
   input  logic [WB_XLEN-1:0] raw_i,
   input  logic [2:0]         byte_addr_i,
   input  logic [3:0]         width_1h_i,
   input  logic               sign_i,
   output logic [WB_XLEN-1:0] data_o
);

   logic [WB_XLEN-1:0] shifted;

   assign shifted = raw_i >> {byte_addr_i, 3'b000};

   always_comb begin
      // NOTE: assign a default before the case so no path leaves data_o unassigned (no latch).
      data_o = '0;
      case (width_1h_i)
         MEM_WIDTH_1H_BYTE:   data_o = {{56{sign_i & shifted[7]}},  shifted[7:0]};
         MEM_WIDTH_1H_HALF:   data_o = {{48{sign_i & shifted[15]}}, shifted[15:0]};
         MEM_WIDTH_1H_WORD:   data_o = {{32{sign_i & shifted[31]}}, shifted[31:0]};
         MEM_WIDTH_1H_DOUBLE: data_o = shifted;
         default:             data_o = '0;
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: load buffering, write-back source selection, register-file
// write port and the instret counter. Only XLEN=64 is supported.
module writeback_stage
   import writeback_stage_pkg::*;
#(
   parameter int unsigned XLEN = WB_XLEN
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            stall_i,
   input  logic            valid_i,
   input  logic [XLEN-1:0] rd_data_i,
   input  logic [4:0]      rd_idx_i,
   input  logic            rd_wr_en_i,
   input  logic [2:0]      rd_wr_src_1h_i,
   input  logic [3:0]      mem_width_1h_i,
   input  logic            mem_sign_i,
   input  logic [2:0]      byte_addr_i,
   input  logic [XLEN-1:0] csr_rdata_i,
   input  logic [XLEN-1:0] dmem_rdata_i,
   input  logic            dmem_rvalid_i,
   output logic            load_stall_o,
   output logic            rf_wr_en_o,
   output logic [4:0]      rf_wr_idx_o,
   output logic [XLEN-1:0] rf_wr_data_o,
   output logic [XLEN-1:0] instret_o
);

   lb_state_e       state_q, state_d;
   logic [XLEN-1:0] load_buf_q, load_buf_d;
   logic [XLEN-1:0] instret_q, instret_d;

   logic            is_load;
   logic            load_held;
   logic            load_avail;
   logic            retire;
   logic [XLEN-1:0] load_raw;
   logic [XLEN-1:0] load_data;
   logic [XLEN-1:0] wb_data;

   assign is_load    = valid_i & |(rd_wr_src_1h_i & WB_SRC_1H_MEM);
   assign load_held  = (state_q == LB_HELD);
   assign load_avail = load_held | dmem_rvalid_i;
   assign load_raw   = load_held ? load_buf_q : dmem_rdata_i;

   // Reset gates both so nothing retires or stalls while the stage is being cleared.
   assign load_stall_o = ~rst_i & is_load & ~load_avail;
   assign retire       = ~rst_i & valid_i & ~stall_i & (~is_load | load_avail);

   writeback_stage_load_align_ext u_align (
      .raw_i       (load_raw),
      .byte_addr_i (byte_addr_i),
      .width_1h_i  (mem_width_1h_i),
      .sign_i      (mem_sign_i),
      .data_o      (load_data)
   );

   assign wb_data = ({XLEN{|(rd_wr_src_1h_i & WB_SRC_1H_ALU)}} & rd_data_i)
                  | ({XLEN{|(rd_wr_src_1h_i & WB_SRC_1H_MEM)}} & load_data)
                  | ({XLEN{|(rd_wr_src_1h_i & WB_SRC_1H_CSR)}} & csr_rdata_i);

   assign rf_wr_en_o   = retire & rd_wr_en_i & (rd_idx_i != 5'd0);
   assign rf_wr_idx_o  = rd_idx_i;
   assign rf_wr_data_o = wb_data;
   assign instret_o    = instret_q;

   // A response that lands during a stall is parked until the load can retire;
   // a second response while parked is a protocol error and is dropped.
   always_comb begin
      state_d    = state_q;
      load_buf_d = load_buf_q;
      case (state_q)
         LB_IDLE: begin
            if (dmem_rvalid_i & stall_i) begin
               state_d    = LB_HELD;
               load_buf_d = dmem_rdata_i;
            end
         end
         LB_HELD: begin
            if (is_load & ~stall_i) begin
               state_d = LB_IDLE;
            end
         end
         default: state_d = LB_IDLE;
      endcase
   end

   assign instret_d = retire ? instret_q + XLEN'(1) : instret_q;

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= LB_IDLE;
         // NOTE: the single-entry buffer is explicitly cleared; a mid-load reset must drop it.
         load_buf_q <= '0;
         instret_q  <= '0;
      end else begin
         state_q    <= state_d;
         load_buf_q <= load_buf_d;
         instret_q  <= instret_d;
      end
   end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios followed by
// randomized traffic compared against a behavioural model.
module tb_writeback_stage;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        stall_i;
   logic        valid_i;
   logic [63:0] rd_data_i;
   logic [4:0]  rd_idx_i;
   logic        rd_wr_en_i;
   logic [2:0]  rd_wr_src_1h_i;
   logic [3:0]  mem_width_1h_i;
   logic        mem_sign_i;
   logic [2:0]  byte_addr_i;
   logic [63:0] csr_rdata_i;
   logic [63:0] dmem_rdata_i;
   logic        dmem_rvalid_i;
   logic        load_stall_o;
   logic        rf_wr_en_o;
   logic [4:0]  rf_wr_idx_o;
   logic [63:0] rf_wr_data_o;
   logic [63:0] instret_o;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   bit          m_held = 1'b0;
   logic [63:0] m_buf  = '0;
   logic [63:0] m_instret = '0;

   always #5 clk_i = ~clk_i;

   writeback_stage dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .stall_i        (stall_i),
      .valid_i        (valid_i),
      .rd_data_i      (rd_data_i),
      .rd_idx_i       (rd_idx_i),
      .rd_wr_en_i     (rd_wr_en_i),
      .rd_wr_src_1h_i (rd_wr_src_1h_i),
      .mem_width_1h_i (mem_width_1h_i),
      .mem_sign_i     (mem_sign_i),
      .byte_addr_i    (byte_addr_i),
      .csr_rdata_i    (csr_rdata_i),
      .dmem_rdata_i   (dmem_rdata_i),
      .dmem_rvalid_i  (dmem_rvalid_i),
      .load_stall_o   (load_stall_o),
      .rf_wr_en_o     (rf_wr_en_o),
      .rf_wr_idx_o    (rf_wr_idx_o),
      .rf_wr_data_o   (rf_wr_data_o),
      .instret_o      (instret_o)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Load extraction from first principles: pick N bytes starting at byte_addr.
   function automatic logic [63:0] ref_ext(input logic [63:0] raw, input logic [2:0] addr,
                                           input logic [3:0] w, input logic sgn);
      int          nbits;
      logic [63:0] v;
      logic [63:0] mask;
      case (w)
         4'd1:    nbits = 8;
         4'd2:    nbits = 16;
         4'd4:    nbits = 32;
         4'd8:    nbits = 64;
         default: return 64'd0;
      endcase
      v    = raw >> (8 * int'(addr));
      mask = (nbits == 64) ? {64{1'b1}} : ((64'd1 << nbits) - 64'd1);
      v    = v & mask;
      if (sgn && v[nbits-1]) v = v | ~mask;
      return v;
   endfunction

   task automatic idle_in();
      valid_i        = 1'b0;
      stall_i        = 1'b0;
      rd_data_i      = '0;
      rd_idx_i       = '0;
      rd_wr_en_i     = 1'b0;
      rd_wr_src_1h_i = '0;
      mem_width_1h_i = '0;
      mem_sign_i     = 1'b0;
      byte_addr_i    = '0;
      csr_rdata_i    = '0;
      dmem_rdata_i   = '0;
      dmem_rvalid_i  = 1'b0;
   endtask

   task automatic drive_alu(input logic [4:0] idx, input logic [63:0] d);
      idle_in();
      valid_i        = 1'b1;
      rd_wr_src_1h_i = 3'b001;
      rd_wr_en_i     = 1'b1;
      rd_idx_i       = idx;
      rd_data_i      = d;
   endtask

   task automatic drive_load(input logic [3:0] w, input logic sgn, input logic [2:0] addr,
                             input logic [4:0] idx, input logic [63:0] rdata, input logic rv);
      idle_in();
      valid_i        = 1'b1;
      rd_wr_src_1h_i = 3'b010;
      rd_wr_en_i     = 1'b1;
      rd_idx_i       = idx;
      mem_width_1h_i = w;
      mem_sign_i     = sgn;
      byte_addr_i    = addr;
      dmem_rdata_i   = rdata;
      dmem_rvalid_i  = rv;
   endtask

   // One clock: compare combinational outputs against the model, advance the
   // model on the edge, then compare the counter.
   task automatic cycle();
      bit          is_load, avail, exp_stall, exp_retire, exp_en;
      logic [63:0] raw, exp_data;
      #1;
      assert (!(m_held && dmem_rvalid_i)) else $error("stimulus drove rvalid while a load is held");
      is_load    = valid_i && rd_wr_src_1h_i[1];
      avail      = m_held || dmem_rvalid_i;
      raw        = m_held ? m_buf : dmem_rdata_i;
      exp_stall  = !rst_i && is_load && !avail;
      exp_retire = !rst_i && valid_i && !stall_i && (!is_load || avail);
      exp_en     = exp_retire && rd_wr_en_i && (rd_idx_i != 5'd0);
      exp_data   = '0;
      if (rd_wr_src_1h_i[0]) exp_data = exp_data | rd_data_i;
      if (rd_wr_src_1h_i[1]) exp_data = exp_data | ref_ext(raw, byte_addr_i, mem_width_1h_i, mem_sign_i);
      if (rd_wr_src_1h_i[2]) exp_data = exp_data | csr_rdata_i;
      check("load_stall", 64'(load_stall_o), 64'(exp_stall));
      check("rf_wr_en",   64'(rf_wr_en_o),   64'(exp_en));
      check("rf_wr_idx",  64'(rf_wr_idx_o),  64'(rd_idx_i));
      check("rf_wr_data", rf_wr_data_o,      exp_data);
      @(posedge clk_i);
      if (rst_i) begin
         m_held    = 1'b0;
         m_buf     = '0;
         m_instret = '0;
      end else begin
         if (!m_held && dmem_rvalid_i && stall_i) begin
            m_held = 1'b1;
            m_buf  = dmem_rdata_i;
         end else if (m_held && is_load && !stall_i) begin
            m_held = 1'b0;
         end
         if (exp_retire) m_instret = m_instret + 64'd1;
      end
      @(negedge clk_i);
      check("instret", instret_o, m_instret);
   endtask

   initial begin
      idle_in();
      rst_i = 1'b1;
      @(negedge clk_i);

      // Reset: a valid ALU op must not write or count
      drive_alu(5'd5, 64'h55);
      #1;
      check("rst_wr_en", 64'(rf_wr_en_o), 64'd0);
      check("rst_stall", 64'(load_stall_o), 64'd0);
      cycle();
      check("rst_instret", instret_o, 64'd0);
      rst_i = 1'b0;

      // 1: ALU write, same cycle
      drive_alu(5'd5, 64'h1234);
      #1;
      check("t1_en",   64'(rf_wr_en_o), 64'd1);
      check("t1_idx",  64'(rf_wr_idx_o), 64'd5);
      check("t1_data", rf_wr_data_o, 64'h1234);
      cycle();
      check("t1_instret", instret_o, 64'd1);

      // 2: LB / LBU at byte 3
      drive_load(4'b0001, 1'b1, 3'd3, 5'd6, 64'h0000_0000_80FF_0000, 1'b1);
      #1;
      check("t2_lb", rf_wr_data_o, 64'hFFFF_FFFF_FFFF_FF80);
      cycle();
      drive_load(4'b0001, 1'b0, 3'd3, 5'd6, 64'h0000_0000_80FF_0000, 1'b1);
      #1;
      check("t2_lbu", rf_wr_data_o, 64'h80);
      cycle();

      // 3: LW with response two cycles late
      repeat (2) begin
         drive_load(4'b0100, 1'b1, 3'd0, 5'd7, 64'hDEAD_BEEF_0BAD_F00D, 1'b0);
         #1;
         check("t3_stall", 64'(load_stall_o), 64'd1);
         check("t3_no_wr", 64'(rf_wr_en_o), 64'd0);
         cycle();
      end
      drive_load(4'b0100, 1'b1, 3'd0, 5'd7, 64'h0000_0001_8765_4321, 1'b1);
      #1;
      check("t3_en",   64'(rf_wr_en_o), 64'd1);
      check("t3_data", rf_wr_data_o, 64'hFFFF_FFFF_8765_4321);
      cycle();
      check("t3_instret", instret_o, 64'd4);

      // 4: LD response during stall, held for 3 more stalled cycles
      drive_load(4'b1000, 1'b0, 3'd0, 5'd8, 64'hCAFE_F00D_1234_5678, 1'b1);
      stall_i = 1'b1;
      cycle();
      repeat (3) begin
         drive_load(4'b1000, 1'b0, 3'd0, 5'd8, 64'h1111_2222_3333_4444, 1'b0);
         stall_i = 1'b1;
         #1;
         check("t4_held_nostall", 64'(load_stall_o), 64'd0);
         cycle();
      end
      drive_load(4'b1000, 1'b0, 3'd0, 5'd8, 64'h1111_2222_3333_4444, 1'b0);
      #1;
      check("t4_en",   64'(rf_wr_en_o), 64'd1);
      check("t4_data", rf_wr_data_o, 64'hCAFE_F00D_1234_5678);
      cycle();
      drive_load(4'b1000, 1'b0, 3'd0, 5'd8, 64'h0, 1'b0);
      #1;
      check("t4_back_idle", 64'(load_stall_o), 64'd1);
      cycle();
      drive_load(4'b0011, 1'b1, 3'd0, 5'd8, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      #1;
      check("bad_width", rf_wr_data_o, 64'd0);
      cycle();

      // 5: rd=x0, bubble, instret wrap
      drive_alu(5'd0, 64'h99);
      #1;
      check("t5_x0", 64'(rf_wr_en_o), 64'd0);
      cycle();
      idle_in();
      cycle();
      force dut.instret_q = {64{1'b1}};
      #1;
      release dut.instret_q;
      m_instret = {64{1'b1}};
      drive_alu(5'd9, 64'h77);
      cycle();
      check("t5_wrap", instret_o, 64'd0);

      // 6: reset while HELD
      drive_load(4'b1000, 1'b0, 3'd0, 5'd10, 64'hABCD_0000_0000_0001, 1'b1);
      stall_i = 1'b1;
      cycle();
      rst_i = 1'b1;
      drive_load(4'b1000, 1'b0, 3'd0, 5'd10, 64'h0, 1'b0);
      #1;
      check("t6_no_wr", 64'(rf_wr_en_o), 64'd0);
      cycle();
      rst_i = 1'b0;
      check("t6_instret", instret_o, 64'd0);
      drive_load(4'b1000, 1'b0, 3'd0, 5'd10, 64'h0, 1'b0);
      #1;
      check("t6_stall", 64'(load_stall_o), 64'd1);
      cycle();
      drive_load(4'b1000, 1'b0, 3'd0, 5'd10, 64'h0123_4567_89AB_CDEF, 1'b1);
      #1;
      check("t6_fresh", rf_wr_data_o, 64'h0123_4567_89AB_CDEF);
      cycle();

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [2:0] srcs[3] = '{3'b001, 3'b010, 3'b100};
         logic [3:0] wids[4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
         rst_i          = ($urandom_range(0, 63) == 0);
         valid_i        = ($urandom_range(0, 3) != 0);
         stall_i        = ($urandom_range(0, 3) == 0);
         rd_wr_src_1h_i = ($urandom_range(0, 7) == 0) ? 3'($urandom) : srcs[$urandom_range(0, 2)];
         rd_wr_en_i     = 1'($urandom);
         rd_idx_i       = 5'($urandom);
         rd_data_i      = {$urandom, $urandom};
         mem_width_1h_i = ($urandom_range(0, 7) == 0) ? 4'($urandom) : wids[$urandom_range(0, 3)];
         mem_sign_i     = 1'($urandom);
         byte_addr_i    = 3'($urandom);
         csr_rdata_i    = {$urandom, $urandom};
         dmem_rdata_i   = {$urandom, $urandom};
         dmem_rvalid_i  = m_held ? 1'b0 : 1'($urandom);
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
